uart_recv: RTL and testbench

- UART receiver: the receive-side counterpart of the board UART transmitter.
- Samples asynchronous serial_in (8N1, LSB first, idle high) and assembles bytes.
- Presents each byte on a valid/ready output port to the CPU MMIO UART register block.
- Flags framing errors and overruns.

---
 rtl/uart_recv.sv | 100 ++++++++++
 tb/tb_uart_recv.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_recv.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a one-entry
// valid/ready holding register with framing-error and overrun pulses.
module uart_recv #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);
  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CW               = $clog2(SYMBOL_EDGE_TIME) + 1;
  localparam logic [CW-1:0] EDGE_LAST   = CW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state, state_nxt;
  logic          sync1, rx;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          shift_en, deliver, stop_bad;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rx    <= 1'b1;
    end else begin
      sync1 <= serial_in;
      rx    <= sync1;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    deliver   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE:      if (!rx) state_nxt = START;
      // Start bit re-checked at its midpoint so short glitches are ignored.
      START:     if (cnt == SAMPLE_LAST) state_nxt = rx ? IDLE : DATA;
      DATA:      if (cnt == EDGE_LAST) begin
                   shift_en = 1'b1;
                   if (bit_idx == 3'd7) state_nxt = STOP;
                 end
      STOP:      if (cnt == EDGE_LAST) begin
                   if (rx) begin
                     deliver   = 1'b1;
                     state_nxt = IDLE;
                   end else begin
                     stop_bad  = 1'b1;
                     state_nxt = WAIT_HIGH;
                   end
                 end
      // A held-low (break) line must return high before a new start is accepted.
      WAIT_HIGH: if (rx) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      shift          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      framing_error  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      state         <= state_nxt;
      framing_error <= stop_bad;
      overrun       <= deliver & data_out_valid & ~data_out_ready;

      if (state_nxt != state || (state == DATA && cnt == EDGE_LAST)) cnt <= '0;
      else                                                          cnt <= cnt + 1'b1;

      if (state == START)  bit_idx <= '0;
      else if (shift_en)   bit_idx <= bit_idx + 3'd1;
      if (shift_en)        shift[bit_idx] <= rx;

      // Same-cycle consume and load keeps valid high with the new byte.
      if (deliver && (!data_out_valid || data_out_ready)) begin
        data_out       <= shift;
        data_out_valid <= 1'b1;
      end else if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv at 10 clocks per bit; a byte scoreboard is filled
// when frames are sent and drained on every valid&ready transfer.
module tb_uart_recv;
  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;

  int         n_cmp = 0, n_err = 0;
  int         cyc = 0, fe_cnt, ov_cnt, vcyc, xfer_cnt, rise_cyc, c0, lat;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_recv #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .data_out(data_out),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .framing_error(framing_error), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe outputs at negedge (inputs already settled for the next posedge), then advance.
  task automatic tick();
    @(negedge clk);
    if (framing_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if (data_out_valid) vcyc++;
    if (data_out_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
    prev_valid = data_out_valid;
    if (data_out_valid && data_out_ready) begin
      xfer_cnt++;
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL spurious_xfer: observed byte %02h expected none", data_out);
      end
      if (exp_q.size() > 0) check("xfer_data", data_out, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) tick();
  endtask

  // Transmitter model: 10 ticks per bit; optional one-cycle ready pulse at tick pulse_at.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int pulse_at, input int len);
    for (int i = 0; i < len; i++) begin
      if (i < 10)      serial_in = 1'b0;
      else if (i < 90) serial_in = b[(i - 10) / 10];
      else             serial_in = stop;
      if (i == pulse_at) data_out_ready = 1'b1;
      else if (pulse_at >= 0 && i == pulse_at + 1) data_out_ready = 1'b0;
      tick();
    end
  endtask

  task automatic clear_stats();
    fe_cnt = 0; ov_cnt = 0; vcyc = 0; xfer_cnt = 0; rise_cyc = -1;
  endtask

  initial begin
    clear_stats();
    reset = 1'b0; serial_in = 1'b1; data_out_ready = 1'b1;
    repeat (3) tick();
    check("rst_data", data_out, 8'h00);
    check("rst_valid", data_out_valid, 1'b0);
    check("rst_fe", framing_error, 1'b0);
    check("rst_ov", overrun, 1'b0);
    reset = 1'b1;
    idle(20);

    // Basic receive with latency
    clear_stats();
    c0 = cyc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1, 100);
    idle(30);
    lat = rise_cyc - c0;
    n_cmp++;
    assert (lat >= 97 && lat <= 99) else begin
      n_err++;
      $error("FAIL t1_latency: observed %0d expected 98+-1", lat);
    end
    check("t1_vcyc", vcyc, 1);
    check("t1_fe", fe_cnt, 0);
    check("t1_ov", ov_cnt, 0);
    check("t1_q", exp_q.size(), 0);

    // Glitch rejection
    clear_stats();
    serial_in = 1'b0;
    repeat (3) tick();
    idle(200);
    check("t2_vcyc", vcyc, 0);
    check("t2_fe", fe_cnt, 0);
    check("t2_ov", ov_cnt, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, -1, 100);
    idle(30);
    check("t2_q", exp_q.size(), 0);
    check("t2_vcyc2", vcyc, 1);

    // Framing error with held-low line
    clear_stats();
    send_frame(8'h81, 1'b0, -1, 100);
    serial_in = 1'b0;
    repeat (30) tick();
    idle(150);
    check("t3_fe", fe_cnt, 1);
    check("t3_vcyc", vcyc, 0);
    check("t3_ov", ov_cnt, 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, -1, 100);
    idle(30);
    check("t3_q", exp_q.size(), 0);
    check("t3_vcyc2", vcyc, 1);

    // Overrun
    clear_stats();
    data_out_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1, 100);
    send_frame(8'h22, 1'b1, -1, 100);
    idle(20);
    check("t4_ov", ov_cnt, 1);
    check("t4_data", data_out, 8'h11);
    check("t4_valid", data_out_valid, 1'b1);
    check("t4_fe", fe_cnt, 0);
    data_out_ready = 1'b1;
    idle(5);
    check("t4_xfer", xfer_cnt, 1);
    check("t4_valid_drop", data_out_valid, 1'b0);
    check("t4_q", exp_q.size(), 0);

    // Simultaneous consume and load
    clear_stats();
    data_out_ready = 1'b0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, -1, 100);
    send_frame(8'h22, 1'b1, 97, 100);
    idle(20);
    check("t5_ov", ov_cnt, 0);
    check("t5_valid", data_out_valid, 1'b1);
    check("t5_data", data_out, 8'h22);
    check("t5_xfer", xfer_cnt, 1);
    data_out_ready = 1'b1;
    idle(5);
    check("t5_q", exp_q.size(), 0);
    check("t5_xfer2", xfer_cnt, 2);

    // Reset during bit 4 of 0xF0
    clear_stats();
    send_frame(8'hF0, 1'b1, -1, 55);
    reset = 1'b0;
    serial_in = 1'b1;
    repeat (3) tick();
    check("t6_rst_data", data_out, 8'h00);
    check("t6_rst_valid", data_out_valid, 1'b0);
    reset = 1'b1;
    idle(200);
    check("t6_vcyc", vcyc, 0);
    check("t6_fe", fe_cnt, 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1, 100);
    idle(30);
    check("t6_q", exp_q.size(), 0);
    check("t6_vcyc2", vcyc, 1);

    // Back-to-back stream from the transmitter model
    clear_stats();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    send_frame(8'h00, 1'b1, -1, 100);
    send_frame(8'hFF, 1'b1, -1, 100);
    send_frame(8'h55, 1'b1, -1, 100);
    idle(30);
    check("lb_xfer", xfer_cnt, 3);
    check("lb_q", exp_q.size(), 0);
    check("lb_fe", fe_cnt, 0);
    check("lb_ov", ov_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
